// File: rtl/cfetch_pkg.sv
// Shared types and constants for the compressed-instruction fetch sequencer.
package cfetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Low two bits of a halfword that mark a full 32-bit (non-compressed) encoding.
    localparam logic [1:0] NONC_OPCODE = 2'b11;

    function automatic logic is_noncompressed(input logic [HALF_W-1:0] hw);
        return hw[1:0] == NONC_OPCODE;
    endfunction

endpackage

// File: rtl/cfetch_sequencer_if.sv
// Memory, decoder and redirect signals of the fetch sequencer, bundled into one interface.
interface cfetch_sequencer_if
    import cfetch_pkg::*;
#(
    parameter int PC_W = 16
) ();

    // Instruction memory request/response
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rsp_valid;
    logic [WORD_W-1:0] imem_rdata;

    // Decoder handshake
    logic              instr_valid;
    logic              instr_ready;
    logic [HALF_W-1:0] instr;
    logic [PC_W-1:0]   instr_pc;
    logic              instr_illegal;

    // Branch resolution
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    // Sequencer side
    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rdata,
        output instr_valid, instr, instr_pc, instr_illegal,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    // Memory / decoder / branch-unit side
    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rdata,
        input  instr_valid, instr, instr_pc, instr_illegal,
        output instr_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/cfetch_sequencer.sv
// Fetch sequencer: reads 32-bit words, issues their two 16-bit halves to the
// decoder one at a time, and restarts on branch redirects (draining any
// outstanding read whose data is no longer wanted).
module cfetch_sequencer
    import cfetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
    cfetch_sequencer_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              half_sel_q, half_sel_d;
    logic [PC_W-1:0]   redirect_tgt;
    logic [HALF_W-1:0] cur_half;

    // Redirect target with bit 0 forced to zero (halfword aligned).
    assign redirect_tgt = bus.redirect_pc & ~PC_W'(1);

    // Halfword currently presented to the decoder.
    assign cur_half = half_sel_q ? buf_q[WORD_W-1:HALF_W] : buf_q[HALF_W-1:0];

    assign bus.imem_req_valid = (state_q == FETCH) && !reset;
    assign bus.imem_addr      = {pc_q[PC_W-1:2], 2'b00};
    assign bus.instr_valid    = (state_q == ISSUE);
    assign bus.instr          = cur_half;
    assign bus.instr_pc       = pc_q;
    assign bus.instr_illegal  = is_noncompressed(cur_half);

    // State, pc, word buffer and half select registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            half_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            half_sel_q <= half_sel_d;
        end
    end

    // Next-state logic; a redirect overrides every other event in each state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        half_sel_d = half_sel_q;

        case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A request granted this cycle carries the old address.
                    state_d = bus.imem_req_ready ? DRAIN : FETCH;
                end else if (bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_rsp_valid ? FETCH : DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    buf_d      = bus.imem_rdata;
                    half_sel_d = pc_q[1];
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
                if (bus.redirect_valid) begin
                    // Any same-cycle decoder handshake is discarded.
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (bus.instr_ready) begin
                    pc_d = pc_q + PC_W'(2);
                    if (!half_sel_q) begin
                        half_sel_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (bus.imem_rsp_valid) begin
                    state_d = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

endmodule

// File: doc/cfetch_sequencer.md
Name: cfetch_sequencer

Overview:
Fetch sequencer for the 16-bit compressed-instruction decode path. Issues 32-bit word reads to instruction memory, splits each word into two 16-bit halfwords and presents them one at a time to the decoder over a valid/ready handshake. Handles branch redirects from beqz/bnez resolution, including discarding a read that is still outstanding. Sits between instruction memory and the decoder.

Parameters:
PC_W, 16, byte-address width of the PC and of imem_addr
RESET_PC, 0, fetch address after reset; bit 0 must be 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_req_valid  out  1  word read request
imem_req_ready  in  1  memory accepts the request this cycle
imem_addr  out  PC_W  word-aligned read address; bits [1:0] = 0
imem_rsp_valid  in  1  read data valid; exactly one response per accepted request
imem_rdata  in  32  read word; [15:0] = lower halfword, [31:16] = upper halfword
instr_valid  out  1  instr is presented to the decoder
instr_ready  in  1  decoder consumes instr
instr  out  16  current compressed instruction
instr_pc  out  PC_W  byte address of instr
instr_illegal  out  1  instr[1:0] == 2'b11 (not a compressed encoding); qualified by instr_valid
redirect_valid  in  1  branch taken; restart fetch
redirect_pc  in  PC_W  target address; bit 0 is ignored and treated as 0

Behaviour:
- Reset (asynchronous): state = FETCH, pc = RESET_PC, instr_valid = 0, instr = 0, instr_pc = RESET_PC, imem_req_valid = 0 while reset is asserted. The first request appears in the first cycle after reset deasserts.
- Only one memory request may be outstanding.
- pc is the byte address of the next halfword. It increments by 2 and wraps modulo 2^PC_W.
- State FETCH:
  - Drive imem_req_valid = 1 and imem_addr = {pc[PC_W-1:2], 2'b00}. instr_valid = 0.
  - On imem_req_ready, go to WAIT.
- State WAIT:
  - On imem_rsp_valid, latch imem_rdata into the word buffer, set half_sel = pc[1], and go to ISSUE. instr_valid = 1 in the next cycle.
  - Response-to-instr_valid latency: 1 cycle.
- State ISSUE:
  - instr = buffer[half_sel], instr_pc = pc, instr_valid = 1. instr and instr_pc hold stable until the handshake completes.
  - On instr_ready with half_sel = 0: half_sel = 1, pc += 2, stay in ISSUE (back-to-back issue).
  - On instr_ready with half_sel = 1: pc += 2, go to FETCH.
- State DRAIN:
  - Entered when a request is outstanding at the time of a redirect.
  - Wait for imem_rsp_valid and discard the data, then go to FETCH.
  - No new request is issued while in DRAIN.
- Redirect has priority over all other events in every state. pc = {redirect_pc[PC_W-1:1], 1'b0}.
  - In FETCH without imem_req_ready, or in ISSUE: go to FETCH. instr_valid = 0 in the next cycle. A same-cycle instr_ready handshake is void.
  - In FETCH with imem_req_ready in the same cycle: the request was issued with the old address, so go to DRAIN.
  - In WAIT without imem_rsp_valid: go to DRAIN.
  - In WAIT with imem_rsp_valid in the same cycle: discard the response and go to FETCH.
  - In DRAIN: update pc, stay in DRAIN. A response arriving in the same cycle is discarded and the next state is FETCH.
- Target with redirect_pc[1] = 1: the word is fetched and only the upper half is issued.
- instr_illegal is a combinational decode of the buffered halfword. The sequencer does not stall on it; the decoder decides what to do.
- Reset mid-operation: any outstanding response arriving after reset deasserts while in FETCH is ignored. Memory must be reset together with this block.

Decomposition:
- Package cfetch_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, ISSUE, DRAIN}
  - HALF_W = 16, WORD_W = 32
  - the constant 2'b11 used for the non-compressed test
- No sub-module. The word buffer and half select are small enough to live inline.

Test Plan:
- Reset release, RESET_PC = 0, memory returns 0x4501_8D05 one cycle after grant, instr_ready = 1 -> imem_addr = 0x0000, then instr 0x8D05 at pc 0x0000, instr 0x4501 at pc 0x0002 on consecutive cycles, then request 0x0004.
- Decoder backpressure: instr_ready = 0 for 3 cycles in ISSUE -> instr and instr_pc held stable, no new imem request until the upper half is consumed.
- Redirect to 0x0012 while in ISSUE with half_sel = 0 -> next request addr 0x0010, and only the upper halfword issues, with instr_pc = 0x0012.
- Redirect to 0x0040 while in WAIT -> DRAIN, stale response is discarded with no instr_valid, next request addr 0x0040.
- Redirect in the same cycle as imem_req_ready -> DRAIN. Redirect in the same cycle as imem_rsp_valid -> FETCH directly, response dropped.
- PC_W = 16, redirect to 0xFFFC, both halves consumed -> next request addr 0x0000 (wrap). Word 0x0000_0003 -> instr_illegal = 1 for the lower half, 0 for the upper half.
